aes256_cipher_core: RTL and testbench

- Iterative AES-256 encryption engine: one block in, 14 rounds at one round per clock, one block out.
- Sits directly downstream of the combinational 60-word key expansion and consumes its full 1920-bit round-key bus.
- Sits upstream of the mode/IO logic through a valid/ready handshake on both sides.
- Vectors are big-endian: bit 0 is the MSB of byte 0, matching the key-expansion bus.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_round.sv | 30 +++
 rtl/aes256_cipher_core.sv | 122 ++++++++++++
 tb/tb_aes256_cipher_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES primitives: S-box table, GF(2^8) helpers and the cipher FSM state type.
// Used by the encrypt core and its round datapath; the decrypt path reuses these later.
package aes_pkg;

   localparam int AES_NB    = 4;
   localparam int AES256_NK = 8;
   localparam int AES256_NR = 14;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } aes_state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   // Multiply by x in GF(2^8), reducing with 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte n of the state sits at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
import aes_pkg::*;

module aes_round (
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         final_rnd,
   output logic [127:0] state_out
);

   logic [127:0] sr;
   logic [127:0] mc;

   always_comb begin
      sr = '0;
      mc = '0;
      // Row r of output column c comes from input column (c+r) mod 4.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[127-8*(4*c+r) -: 8] = sbox(state_in[127-8*(4*((c+r)%4)+r) -: 8]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
      end
      state_out = (final_rnd ? sr : mc) ^ round_key;
   end

endmodule

// File: rtl/aes256_cipher_core.sv
// Iterative AES-256 encrypt core, one round per clock, valid/ready on both sides.
// Optional AES256_KEY_LATCH_EN captures the round-key bus at accept so upstream may change it.
import aes_pkg::*;

module aes256_cipher_core #(
   parameter int NR   = 14,
   parameter int RK_W = 1920
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [127:0]    in_block,
   input  logic [RK_W-1:0] round_keys,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [127:0]    out_block,
   output logic            busy
);

   aes_state_e   state_q, state_d;
   logic [3:0]   rnd_q;
   logic [127:0] blk_q;
   logic [127:0] round_out;
   logic [127:0] rk_sel;
   logic [RK_W-1:0] rk_src;
   logic         accept;
   logic         last_rnd;

   // The bus is big-endian: word 0 / round key 0 occupy the top bits.
`ifdef AES256_KEY_LATCH_EN
   logic [RK_W-1:0] rk_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rk_q <= '0;
      end else if (accept) begin
         rk_q <= round_keys;
      end
   end

   assign rk_src = rk_q;
`else
   assign rk_src = round_keys;
`endif

   assign last_rnd = (rnd_q == 4'(NR));

   always_comb begin
      rk_sel = '0;
      for (int r = 0; r <= NR; r++) begin
         if (rnd_q == 4'(r)) begin
            rk_sel = rk_src[RK_W-1-128*r -: 128];
         end
      end
   end

   aes_round u_round (
      .state_in  (blk_q),
      .round_key (rk_sel),
      .final_rnd (last_rnd),
      .state_out (round_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = ROUND;
            end
         end
         ROUND: begin
            busy = 1'b1;
            if (last_rnd) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Initial AddRoundKey uses the live bus: a latched copy only exists after this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rnd_q <= '0;
         blk_q <= '0;
      end else if (accept) begin
         blk_q <= in_block ^ round_keys[RK_W-1 -: 128];
         rnd_q <= 4'd1;
      end else if (state_q == ROUND) begin
         blk_q <= round_out;
         if (!last_rnd) begin
            rnd_q <= rnd_q + 4'd1;
         end
      end
   end

   assign out_block = blk_q;

endmodule

// File: tb/tb_aes256_cipher_core.sv
// Scoreboard bench for aes256_cipher_core using FIPS-197 C.3 and SP800-38A F.1.5 vectors.
// Expectations follow the AES256_KEY_LATCH_EN build setting for the key-change case.
`timescale 1ns/1ps
import aes_pkg::*;

module tb_aes256_cipher_core;

   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] F15_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic [127:0] f15_pt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
   logic [127:0] f15_ct [4] = '{128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 128'h591ccb10d410ed26dc5ba74a31362870,
                                128'hb6ed21b99ca6f4f9f153e7b1beafed1d, 128'h23304b7a39f9f3ff067d8d8f9e24ecc7};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  in_block = '0;
   logic [1919:0] round_keys = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [127:0]  out_block;
   logic          busy;

   typedef struct {
      logic [127:0] ct;
      bit           differ;
   } exp_t;

   exp_t sb_q[$];
   int   acc_q[$];
   int   cyc = 0;
   int   errs = 0;
   int   checks = 0;
   logic [1919:0] rk_c3, rk_f15;

   aes256_cipher_core #(.NR(14), .RK_W(1920)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_block   (in_block),
      .round_keys (round_keys),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_block  (out_block),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) acc_q.push_back(cyc);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every output transfer is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         exp_t e;
         checks++;
         if (sb_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_output: got %h expected none", out_block);
         end else begin
            e = sb_q.pop_front();
            if (e.differ ? (out_block === e.ct) : (out_block !== e.ct)) begin
               errs++;
               $display("FAIL ciphertext(differ=%0d): got %h reference %h", e.differ, out_block, e.ct);
            end
         end
      end
   end

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   task automatic expand(input logic [255:0] key, output logic [1919:0] rk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = {rcon[6:0], 1'b0};
         end else if (i % 8 == 4) begin
            t = subw(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int i = 0; i < 60; i++) rk[1919-32*i -: 32] = w[i];
   endtask

   // Presents one block once in_ready is seen; returns just after the accept edge.
   task automatic send(input logic [127:0] pt, input logic [127:0] ct, input bit track,
                       input bit differ, input bit hold);
      exp_t e;
      for (int k = 0; k < 100 && in_ready !== 1'b1; k++) begin
         @(posedge clk); #1;
      end
      if (in_ready !== 1'b1) begin
         checks++; errs++;
         $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
      end
      in_valid = 1'b1;
      in_block = pt;
      if (track) begin
         e.ct = ct; e.differ = differ;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(posedge clk);
      #1;
      chk("drain_pending", 128'(sb_q.size()), 128'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
      chk({tag, "_busy"}, 128'(busy), 128'd0);
      chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
      chk({tag, "_out_block"}, out_block, 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, n_acc, rel, base;
      bit latch_on;
`ifdef AES256_KEY_LATCH_EN
      latch_on = 1'b1;
`else
      latch_on = 1'b0;
`endif
      expand(C3_KEY, rk_c3);
      expand(F15_KEY, rk_f15);
      round_keys = rk_c3;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk_idle("reset");
      rst_n = 1'b1;

      // C.3 with latency measurement.
      out_ready = 1'b1;
      send(C3_PT, C3_CT, 1'b1, 1'b0, 1'b0);
      for (k = 1; k < 40; k++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) break;
      end
      chk("latency_c3", 128'(k), 128'd14);
      wait_drain();

      // F.1.5 block 1.
      round_keys = rk_f15;
      send(f15_pt[0], f15_ct[0], 1'b1, 1'b0, 1'b0);
      wait_drain();

      // Back-pressure with in_valid held high.
      round_keys = rk_c3;
      out_ready = 1'b0;
      send(C3_PT, C3_CT, 1'b1, 1'b0, 1'b1);
      for (k = 0; k < 40 && out_valid !== 1'b1; k++) begin
         @(posedge clk); #1;
      end
      n_acc = acc_q.size();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("bp_hold", {out_valid, in_ready, out_block}, {1'b1, 1'b0, C3_CT});
      end
      chk("bp_no_accept", 128'(acc_q.size()), 128'(n_acc));
      begin
         exp_t e;
         e.ct = C3_CT; e.differ = 1'b0;
         sb_q.push_back(e);
      end
      out_ready = 1'b1;
      rel = cyc;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_second_accept", 128'(acc_q[$]), 128'(rel + 2));
      wait_drain();

      // Reset while the block is at round 7.
      send(C3_PT, C3_CT, 1'b0, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      chk("pre_reset_busy", 128'(busy), 128'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_idle("midreset");
      rst_n = 1'b1;
      send(C3_PT, C3_CT, 1'b1, 1'b0, 1'b0);
      wait_drain();

      // Schedule switched to all-zero right after accept.
      send(C3_PT, C3_CT, 1'b1, !latch_on, 1'b0);
      round_keys = '0;
      wait_drain();

      // Four back-to-back F.1.5 blocks.
      round_keys = rk_f15;
      base = acc_q.size();
      for (int i = 0; i < 4; i++) send(f15_pt[i], f15_ct[i], 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      wait_drain();
      for (int i = 0; i < 3; i++) begin
         if (acc_q.size() > base + i + 1)
            chk("b2b_spacing", 128'(acc_q[base+i+1] - acc_q[base+i]), 128'd16);
         else
            chk("b2b_accepts", 128'(acc_q.size() - base), 128'd4);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
